// File: rtl/jt51_reg_wr.sv
// rtl/jt51_reg_wr.sv - CPU write port and per-channel register update sequencer
// Latches address/data writes and raises update strobes when the channel slot comes around.
module jt51_reg_wr (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic       a0,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       busy,
  output logic [2:0] cur_ch,
  output logic [7:0] wdata,
  output logic       up_rl_ch,
  output logic       up_fb_ch,
  output logic       up_con_ch,
  output logic       up_kc_ch,
  output logic       up_kf_ch,
  output logic       up_ams_ch,
  output logic       up_pms_ch
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t     state, state_nxt;
  logic [7:0] addr;
  logic       wr_prev;
  logic       wr_act, wr_new;
  logic       addr_wr, data_wr;
  logic       in_range, ch_match, upd;

  // Writes are edge-qualified so a strobe held over several clocks counts once
  assign wr_act   = ~cs_n & ~wr_n;
  assign wr_new   = wr_act & ~wr_prev;
  assign addr_wr  = wr_new & ~a0 & ~busy;
  assign data_wr  = wr_new &  a0 & ~busy;

  assign busy     = (state == ST_WAIT);
  assign dout     = {busy, 7'b0};
  assign in_range = (addr[7:5] == 3'b001);
  assign ch_match = (cur_ch == addr[2:0]);
  assign upd      = busy & in_range & ch_match;

  assign up_rl_ch  = upd & (addr[4:3] == 2'b00);
  assign up_fb_ch  = up_rl_ch;
  assign up_con_ch = up_rl_ch;
  assign up_kc_ch  = upd & (addr[4:3] == 2'b01);
  assign up_kf_ch  = upd & (addr[4:3] == 2'b10);
  assign up_ams_ch = upd & (addr[4:3] == 2'b11);
  assign up_pms_ch = up_ams_ch;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (data_wr) state_nxt = ST_WAIT;
      ST_WAIT: if (cen && (ch_match || !in_range)) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      addr    <= 8'h00;
      wdata   <= 8'h00;
      wr_prev <= 1'b0;
      cur_ch  <= 3'd0;
    end else begin
      state   <= state_nxt;
      wr_prev <= wr_act;
      if (addr_wr) addr  <= din;
      if (data_wr) wdata <= din;
      if (cen)     cur_ch <= cur_ch + 3'd1;
    end
  end

endmodule

// File: tb/tb_jt51_reg_wr.sv
// tb/tb_jt51_reg_wr.sv - directed self-checking bench for jt51_reg_wr
module tb_jt51_reg_wr;

  logic       clk = 1'b0;
  logic       rst_n, cen, cs_n, wr_n, a0;
  logic [7:0] din;
  logic [7:0] dout, wdata;
  logic       busy;
  logic [2:0] cur_ch;
  logic       up_rl_ch, up_fb_ch, up_con_ch, up_kc_ch, up_kf_ch, up_ams_ch, up_pms_ch;
  logic [6:0] stb;

  int n_vec = 0;
  int n_err = 0;
  logic [2:0] ch;

  localparam logic [6:0] S_NONE = 7'b0000000;
  localparam logic [6:0] S_RL   = 7'b1110000;
  localparam logic [6:0] S_KC   = 7'b0001000;
  localparam logic [6:0] S_KF   = 7'b0000100;
  localparam logic [6:0] S_AP   = 7'b0000011;

  jt51_reg_wr dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .cs_n(cs_n), .wr_n(wr_n), .a0(a0), .din(din),
    .dout(dout), .busy(busy), .cur_ch(cur_ch), .wdata(wdata),
    .up_rl_ch(up_rl_ch), .up_fb_ch(up_fb_ch), .up_con_ch(up_con_ch), .up_kc_ch(up_kc_ch),
    .up_kf_ch(up_kf_ch), .up_ams_ch(up_ams_ch), .up_pms_ch(up_pms_ch)
  );

  assign stb = {up_rl_ch, up_fb_ch, up_con_ch, up_kc_ch, up_kf_ch, up_ams_ch, up_pms_ch};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic c);
    cen = c;
    @(posedge clk);
    #1;
    cen = 1'b0;
  endtask

  // One cen period: an idle clock then a cen clock
  task automatic cyc();
    step(1'b0);
    step(1'b1);
  endtask

  task automatic cpu_wr(input logic port, input logic [7:0] d);
    cs_n = 1'b0; wr_n = 1'b0; a0 = port; din = d;
    step(1'b0);
    cs_n = 1'b1; wr_n = 1'b1;
    step(1'b0);
  endtask

  initial begin
    rst_n = 1'b0; cen = 1'b0; cs_n = 1'b1; wr_n = 1'b1; a0 = 1'b0; din = 8'h00;
    step(1'b0);
    step(1'b0);
    chk("rst_busy", {7'b0, busy}, 8'h00);
    chk("rst_cur_ch", {5'b0, cur_ch}, 8'h00);
    chk("rst_wdata", wdata, 8'h00);
    chk("rst_dout", dout, 8'h00);
    chk("rst_stb", {1'b0, stb}, {1'b0, S_NONE});
    rst_n = 1'b1;
    cyc();
    chk("first_cen_ch", {5'b0, cur_ch}, 8'h01);
    repeat (4) cyc();
    chk("t1_ch5", {5'b0, cur_ch}, 8'h05);

    // addr 0x2B: kc update for channel 3, requested while slot is 5
    cpu_wr(1'b0, 8'h2B);
    cpu_wr(1'b1, 8'h45);
    chk("t1_busy", {7'b0, busy}, 8'h01);
    chk("t1_wdata", wdata, 8'h45);
    chk("t1_stb0", {1'b0, stb}, {1'b0, S_NONE});
    for (int k = 1; k <= 6; k++) begin
      cyc();
      ch = 3'(5 + k);
      chk("t1_ch", {5'b0, cur_ch}, {5'b0, ch});
      chk("t1_stb", {1'b0, stb}, {1'b0, (ch == 3'd3) ? S_KC : S_NONE});
      chk("t1_busy_hold", {7'b0, busy}, 8'h01);
      chk("t1_wdata_hold", wdata, 8'h45);
    end
    cyc();
    chk("t1_busy_end", {7'b0, busy}, 8'h00);
    chk("t1_stb_end", {1'b0, stb}, {1'b0, S_NONE});
    chk("t1_ch_end", {5'b0, cur_ch}, 8'h04);

    // addr 0x20 with slot already 0: immediate rl/fb/con update
    repeat (4) cyc();
    chk("t2_ch0", {5'b0, cur_ch}, 8'h00);
    cpu_wr(1'b0, 8'h20);
    cpu_wr(1'b1, 8'hC7);
    chk("t2_stb", {1'b0, stb}, {1'b0, S_RL});
    chk("t2_busy", {7'b0, busy}, 8'h01);
    step(1'b0);
    chk("t2_stb_mid", {1'b0, stb}, {1'b0, S_RL});
    step(1'b1);
    chk("t2_stb_end", {1'b0, stb}, {1'b0, S_NONE});
    chk("t2_busy_end", {7'b0, busy}, 8'h00);
    chk("t2_ch", {5'b0, cur_ch}, 8'h01);
    chk("t2_wdata", wdata, 8'hC7);

    // writes during busy are dropped
    cpu_wr(1'b0, 8'h3F);
    cpu_wr(1'b1, 8'h61);
    cpu_wr(1'b0, 8'h30);
    cpu_wr(1'b1, 8'h12);
    chk("t3_wdata", wdata, 8'h61);
    chk("t3_stb0", {1'b0, stb}, {1'b0, S_NONE});
    for (int k = 1; k <= 6; k++) begin
      cyc();
      ch = 3'(1 + k);
      chk("t3_stb", {1'b0, stb}, {1'b0, (ch == 3'd7) ? S_AP : S_NONE});
      chk("t3_busy", {7'b0, busy}, 8'h01);
      chk("t3_wdata_hold", wdata, 8'h61);
    end
    cyc();
    chk("t3_busy_end", {7'b0, busy}, 8'h00);
    chk("t3_ch", {5'b0, cur_ch}, 8'h00);

    // out-of-range address: busy for one cen edge only
    cpu_wr(1'b0, 8'h10);
    cpu_wr(1'b1, 8'hFF);
    chk("t4_busy", {7'b0, busy}, 8'h01);
    chk("t4_dout", dout, 8'h80);
    chk("t4_stb", {1'b0, stb}, {1'b0, S_NONE});
    step(1'b0);
    chk("t4_busy_mid", {7'b0, busy}, 8'h01);
    step(1'b1);
    chk("t4_busy_end", {7'b0, busy}, 8'h00);
    chk("t4_dout_end", dout, 8'h00);
    chk("t4_ch", {5'b0, cur_ch}, 8'h01);

    // reset mid-WAIT aborts a pending kf update on channel 4
    cpu_wr(1'b0, 8'h34);
    cpu_wr(1'b1, 8'hA0);
    cyc();
    chk("t5_busy", {7'b0, busy}, 8'h01);
    chk("t5_ch", {5'b0, cur_ch}, 8'h02);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", {7'b0, busy}, 8'h00);
    chk("t5_rst_ch", {5'b0, cur_ch}, 8'h00);
    chk("t5_rst_dout", dout, 8'h00);
    chk("t5_rst_wdata", wdata, 8'h00);
    repeat (3) step(1'b1);
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      cyc();
      chk("t5_no_stb", {1'b0, stb}, {1'b0, S_NONE});
      chk("t5_no_busy", {7'b0, busy}, 8'h00);
      if (k == 1) chk("t5_ch_after", {5'b0, cur_ch}, 8'h01);
    end
    chk("t5_ch_wrap", {5'b0, cur_ch}, 8'h00);

    // cen frozen for 20 clocks during WAIT
    cpu_wr(1'b0, 8'h2D);
    cpu_wr(1'b1, 8'h5A);
    repeat (2) cyc();
    repeat (20) step(1'b0);
    chk("t6_ch_frozen", {5'b0, cur_ch}, 8'h02);
    chk("t6_busy_frozen", {7'b0, busy}, 8'h01);
    chk("t6_stb_frozen", {1'b0, stb}, {1'b0, S_NONE});
    repeat (3) cyc();
    chk("t6_stb", {1'b0, stb}, {1'b0, S_KC});
    chk("t6_busy", {7'b0, busy}, 8'h01);
    cyc();
    chk("t6_busy_end", {7'b0, busy}, 8'h00);
    chk("t6_ch", {5'b0, cur_ch}, 8'h06);
    chk("t6_wdata", wdata, 8'h5A);

    // a data write held across completion is accepted only once
    cpu_wr(1'b0, 8'h18);
    cs_n = 1'b0; wr_n = 1'b0; a0 = 1'b1; din = 8'h11;
    step(1'b0);
    chk("t7_busy", {7'b0, busy}, 8'h01);
    step(1'b1);
    chk("t7_busy_end", {7'b0, busy}, 8'h00);
    din = 8'h22;
    step(1'b0);
    chk("t7_held_busy", {7'b0, busy}, 8'h00);
    chk("t7_held_wdata", wdata, 8'h11);
    step(1'b1);
    chk("t7_held_busy2", {7'b0, busy}, 8'h00);
    cs_n = 1'b1; wr_n = 1'b1;
    step(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
